arf_retire_ctrl: RTL and testbench
==================================

Name: arf_retire_ctrl

Overview:
- In-order commit sequencer between the ROB head and the architectural register file's two write ports.
- Each cycle, examines the two oldest ROB entries and pops 0, 1 or 2 of them.
- Drives the registered retire1/retire2 write strobes, addresses and data to the register file.
- On a faulting entry, stops retirement, raises a one-cycle flush request and holds off commits for a fixed drain window.

Parameters:
- PREG_W, 6: register-file address width; register file holds 2**PREG_W entries.
- DATA_W, 32: write-data width.
- FLUSH_CYCLES, 4: cycles spent in FLUSH state after a fault; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  when high, no pops and no writes this cycle; state and counters hold.
- h0_valid / h1_valid  in  1  ROB head / head+1 entry present.
- h0_done / h1_done  in  1  entry has completed execution.
- h0_exc / h1_exc  in  1  entry raised an exception.
- h0_wr / h1_wr  in  1  entry writes a destination register.
- h0_dst / h1_dst  in  PREG_W  destination address.
- h0_data / h1_data  in  DATA_W  result value.
- h0_pc / h1_pc  in  32  entry PC.
- pop0  out  1  combinational; head entry consumed this cycle.
- pop1  out  1  combinational; head+1 entry consumed this cycle; implies pop0.
- retire1 / retire2  out  1  registered register-file write enables.
- write_addr1 / write_addr2  out  PREG_W  registered write addresses.
- write_data1 / write_data2  out  DATA_W  registered write data.
- flush_req  out  1  registered one-cycle pulse.
- flush_pc  out  32  PC of the faulting entry; valid with flush_req and held afterwards.
- busy_flush  out  1  high while in FLUSH state.

Behaviour:
- States: RUN, FLUSH.
- Reset (rst high at a clock edge):
  - State = RUN; flush counter = 0.
  - All registered outputs = 0: retire1/2, write_addr1/2, write_data1/2, flush_req, flush_pc.
  - Any pending write is discarded, including a reset that arrives mid-FLUSH.
- pop0/pop1 are 0 whenever any of these holds: rst, freeze, or state FLUSH.
- RUN, slot 0:
  - ok0 = h0_valid & h0_done.
  - pop0 = ok0.
  - If ok0 & ~h0_exc, the write is queued for port 1 when h0_wr.
  - If ok0 & h0_exc: entry popped, no write; flush_req=1 and flush_pc=h0_pc at the next edge; state goes to FLUSH; slot 1 is not popped.
- RUN, slot 1:
  - pop1 = pop0 & ~h0_exc & h1_valid & h1_done.
  - If h1_exc: entry popped, no write, flush as above with h1_pc; slot 0's write still commits.
  - Otherwise the write is queued for port 2 when h1_wr.
- Same-destination collision: both slots write the same dst in one cycle → retire1 is suppressed and only retire2 (the younger entry) writes.
- Latency: pop at cycle N → retire strobes, address and data visible at edge N+1 for exactly one cycle, then cleared unless new pops occur.
- FLUSH:
  - Counter loads FLUSH_CYCLES on entry and decrements each non-frozen cycle.
  - Returns to RUN on the edge where the counter reaches 0, so there are exactly FLUSH_CYCLES cycles with no pops.
  - busy_flush = (state==FLUSH).
- freeze:
  - Outputs registered during a frozen cycle are retire1=retire2=0 and flush_req=0.
  - A flush request already registered is not repeated.
- Ordering: head+1 never retires before the head entry. An invalid or not-done head entry blocks both slots.

Optional Feature:
- Macro RETIRE_STATS_EN.
- When defined, adds outputs stat_retired (32 bits) and stat_flushes (16 bits). Both reset to 0 and wrap on overflow.
- stat_retired increments by the number of pops per cycle, 0/1/2, counting faulting entries.
- stat_flushes increments on each flush_req.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package:
  - state enum {RUN, FLUSH}.
  - PREG_W and DATA_W defaults.
  - a retire-slot struct {valid, done, exc, wr, dst, data, pc}.
- One sub-module, arf_retire_pick: combinational slot-selection logic computing pop0/pop1, the two write enables, the collision suppression and the fault select.
- The parent holds the FSM, flush counter, output registers and stats.

Test Plan:
- Both slots valid/done, h0_dst=5, data=0xA, h1_dst=9, data=0xB → pop0=pop1=1; next cycle retire1 writes 5←0xA and retire2 writes 9←0xB.
- h0_valid=1, h0_done=0, h1 done → pop0=pop1=0; no retire strobes.
- Both slots target dst=12 with data 0x1 then 0x2 → retire1=0, retire2=1 writing 12←0x2.
- h1_exc=1, h1_pc=0x400, FLUSH_CYCLES=4 → slot 0 write commits; flush_req pulses one cycle with flush_pc=0x400; no pops for 4 cycles, then retirement resumes.
- rst asserted on the second FLUSH cycle → next cycle state=RUN, all outputs 0, pops allowed immediately.
- freeze=1 with both slots ready → no pops and no strobes; on release both retire within 1 cycle; with RETIRE_STATS_EN, stat_retired increments by 2.

Source files
------------

// File: rtl/arf_retire_ctrl_pkg.sv
// Shared types for the ARF retire controller: FSM states, width defaults, ROB head slot view.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package arf_retire_ctrl_pkg;

    localparam int PREG_W_DEF = 6;
    localparam int DATA_W_DEF = 32;
    localparam int PC_W       = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // One ROB head entry as seen by the retire logic. The slot fields are
    // sized by the package defaults. A build that overrides PREG_W/DATA_W
    // on the top must change these defaults to match.
    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  exc;
        logic                  wr;
        logic [PREG_W_DEF-1:0] dst;
        logic [DATA_W_DEF-1:0] data;
        logic [PC_W-1:0]       pc;
    } slot_t;

endpackage

// File: rtl/arf_retire_pick.sv
// Combinational slot selection: pops, write enables/addr/data, same-dst collision, fault select.
// Latency: 0 cycles (pure combinational).
// Backpressure: en low (reset, freeze, flush drain) forces every pop, write and fault low.
//
// Ports:
//   en            retirement permitted this cycle
//   s0, s1        ROB head and head+1 slots
//   pop0, pop1    entries consumed (pop1 implies pop0)
//   we1/we2, addr1/addr2, data1/data2   write port requests, zeroed when not writing
//   fault, fault_pc                     a popped entry faulted, and its PC
module arf_retire_pick
    import arf_retire_ctrl_pkg::*;
(
    input  logic                  en,
    input  slot_t                 s0,
    input  slot_t                 s1,
    output logic                  pop0,
    output logic                  pop1,
    output logic                  we1,
    output logic                  we2,
    output logic [PREG_W_DEF-1:0] addr1,
    output logic [PREG_W_DEF-1:0] addr2,
    output logic [DATA_W_DEF-1:0] data1,
    output logic [DATA_W_DEF-1:0] data2,
    output logic                  fault,
    output logic [PC_W-1:0]       fault_pc
);

    logic wr0_raw;
    logic wr1_raw;

    always_comb begin
        pop0 = en & s0.valid & s0.done;
        // A faulting head ends the group, so head+1 stays in the ROB.
        pop1 = pop0 & ~s0.exc & s1.valid & s1.done;

        wr0_raw = pop0 & ~s0.exc & s0.wr;
        wr1_raw = pop1 & ~s1.exc & s1.wr;

        // Both writes hitting one register: the younger result is the
        // architectural value, so port 1 is dropped.
        we1 = wr0_raw & ~(wr1_raw & (s0.dst == s1.dst));
        we2 = wr1_raw;

        addr1 = we1 ? s0.dst  : '0;
        data1 = we1 ? s0.data : '0;
        addr2 = we2 ? s1.dst  : '0;
        data2 = we2 ? s1.data : '0;

        fault    = (pop0 & s0.exc) | (pop1 & s1.exc);
        fault_pc = (pop0 & s0.exc) ? s0.pc : s1.pc;
    end

endmodule

// File: rtl/arf_retire_ctrl.sv
// In-order retire sequencer: pops up to two ROB head entries per cycle into two ARF write ports.
// Latency: pops are combinational; write strobes and flush_req appear one edge after the pop.
// Backpressure: freeze or a fault drain window (FLUSH_CYCLES) blocks all pops; a not-ready head blocks both slots.
//
// Ports: clk, rst (sync, active high), freeze; h0_*/h1_* ROB head/head+1 view;
//   pop0/pop1 (comb); retire1/2, write_addr1/2, write_data1/2 (registered);
//   flush_req, flush_pc, busy_flush.
// Optional: define RETIRE_STATS_EN to add stat_retired[31:0] and stat_flushes[15:0].
module arf_retire_ctrl
    import arf_retire_ctrl_pkg::*;
#(
    parameter int PREG_W       = PREG_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              h0_valid,
    input  logic              h0_done,
    input  logic              h0_exc,
    input  logic              h0_wr,
    input  logic [PREG_W-1:0] h0_dst,
    input  logic [DATA_W-1:0] h0_data,
    input  logic [31:0]       h0_pc,
    input  logic              h1_valid,
    input  logic              h1_done,
    input  logic              h1_exc,
    input  logic              h1_wr,
    input  logic [PREG_W-1:0] h1_dst,
    input  logic [DATA_W-1:0] h1_data,
    input  logic [31:0]       h1_pc,
    output logic              pop0,
    output logic              pop1,
    output logic              retire1,
    output logic              retire2,
    output logic [PREG_W-1:0] write_addr1,
    output logic [PREG_W-1:0] write_addr2,
    output logic [DATA_W-1:0] write_data1,
    output logic [DATA_W-1:0] write_data2,
    output logic              flush_req,
    output logic [31:0]       flush_pc,
    output logic              busy_flush
`ifdef RETIRE_STATS_EN
    ,
    output logic [31:0]       stat_retired,
    output logic [15:0]       stat_flushes
`endif
);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;

    slot_t       s0;
    slot_t       s1;
    logic        en;
    logic        we1;
    logic        we2;
    logic [PREG_W-1:0] addr1;
    logic [PREG_W-1:0] addr2;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic        fault;
    logic [31:0] fault_pc;

    assign s0 = '{valid: h0_valid, done: h0_done, exc: h0_exc, wr: h0_wr,
                  dst: h0_dst, data: h0_data, pc: h0_pc};
    assign s1 = '{valid: h1_valid, done: h1_done, exc: h1_exc, wr: h1_wr,
                  dst: h1_dst, data: h1_data, pc: h1_pc};

    assign en = ~rst & ~freeze & (state == RUN);

    arf_retire_pick u_pick (
        .en       (en),
        .s0       (s0),
        .s1       (s1),
        .pop0     (pop0),
        .pop1     (pop1),
        .we1      (we1),
        .we2      (we2),
        .addr1    (addr1),
        .addr2    (addr2),
        .data1    (data1),
        .data2    (data2),
        .fault    (fault),
        .fault_pc (fault_pc)
    );

    // Next-state: fault enters the drain window; the counter only moves on
    // non-frozen cycles and leaving happens on the edge where it hits zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (fault) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = 4'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (!freeze) begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = 4'd0;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Write-port and flush outputs. Everything requested this cycle is
    // already gated by en, so frozen or draining cycles register zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire1     <= 1'b0;
            retire2     <= 1'b0;
            write_addr1 <= '0;
            write_addr2 <= '0;
            write_data1 <= '0;
            write_data2 <= '0;
            flush_req   <= 1'b0;
            flush_pc    <= '0;
        end else begin
            retire1     <= we1;
            retire2     <= we2;
            write_addr1 <= addr1;
            write_addr2 <= addr2;
            write_data1 <= data1;
            write_data2 <= data2;
            flush_req   <= fault;
            if (fault) begin
                flush_pc <= fault_pc;
            end
        end
    end

    assign busy_flush = (state == FLUSH);

`ifdef RETIRE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_retired <= '0;
            stat_flushes <= '0;
        end else begin
            stat_retired <= stat_retired + {31'd0, pop0} + {31'd0, pop1};
            stat_flushes <= stat_flushes + {15'd0, fault};
        end
    end
`endif

endmodule

// File: tb/tb_arf_retire_ctrl.sv
// Self-checking bench for arf_retire_ctrl: directed cases plus a random run against a scoreboard.
// Latency: expected registered outputs are queued at pop time and compared one edge later.
// Backpressure: exercises freeze, fault drain window and not-ready heads.
module tb_arf_retire_ctrl;

    localparam int FC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        h0_valid, h0_done, h0_exc, h0_wr;
    logic [5:0]  h0_dst;
    logic [31:0] h0_data, h0_pc;
    logic        h1_valid, h1_done, h1_exc, h1_wr;
    logic [5:0]  h1_dst;
    logic [31:0] h1_data, h1_pc;
    logic        pop0, pop1;
    logic        retire1, retire2;
    logic [5:0]  write_addr1, write_addr2;
    logic [31:0] write_data1, write_data2;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        busy_flush;
`ifdef RETIRE_STATS_EN
    logic [31:0] stat_retired;
    logic [15:0] stat_flushes;
`endif

    always #5 clk = ~clk;

    arf_retire_ctrl #(.PREG_W(6), .DATA_W(32), .FLUSH_CYCLES(FC)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .h0_valid    (h0_valid),
        .h0_done     (h0_done),
        .h0_exc      (h0_exc),
        .h0_wr       (h0_wr),
        .h0_dst      (h0_dst),
        .h0_data     (h0_data),
        .h0_pc       (h0_pc),
        .h1_valid    (h1_valid),
        .h1_done     (h1_done),
        .h1_exc      (h1_exc),
        .h1_wr       (h1_wr),
        .h1_dst      (h1_dst),
        .h1_data     (h1_data),
        .h1_pc       (h1_pc),
        .pop0        (pop0),
        .pop1        (pop1),
        .retire1     (retire1),
        .retire2     (retire2),
        .write_addr1 (write_addr1),
        .write_addr2 (write_addr2),
        .write_data1 (write_data1),
        .write_data2 (write_data2),
        .flush_req   (flush_req),
        .flush_pc    (flush_pc),
        .busy_flush  (busy_flush)
`ifdef RETIRE_STATS_EN
        ,
        .stat_retired(stat_retired),
        .stat_flushes(stat_flushes)
`endif
    );

    typedef struct {
        logic        r1, r2;
        logic [5:0]  a1, a2;
        logic [31:0] d1, d2;
        logic        fr;
        logic [31:0] fpc;
        logic        busy;
        logic [31:0] sret;
        logic [15:0] sfl;
    } exp_t;

    exp_t q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_flush = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_fpc   = '0;
    logic [31:0] m_ret   = '0;
    logic [15:0] m_fl    = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set0(input bit v, input bit d, input bit x, input bit w,
                        input logic [5:0] dst, input logic [31:0] dat, input logic [31:0] pc);
        h0_valid = v; h0_done = d; h0_exc = x; h0_wr = w;
        h0_dst = dst; h0_data = dat; h0_pc = pc;
    endtask

    task automatic set1(input bit v, input bit d, input bit x, input bit w,
                        input logic [5:0] dst, input logic [31:0] dat, input logic [31:0] pc);
        h1_valid = v; h1_done = d; h1_exc = x; h1_wr = w;
        h1_dst = dst; h1_data = dat; h1_pc = pc;
    endtask

    // One clock: predict pops and the next registered outputs from the current
    // inputs, check the combinational pops, then compare after the edge.
    task automatic cycle(input string tag);
        bit   en, p0, p1, w1, w2, flt;
        exp_t e;
        exp_t g;
        en  = !rst && !freeze && !m_flush;
        p0  = en && h0_valid && h0_done;
        p1  = p0 && !h0_exc && h1_valid && h1_done;
        w1  = p0 && !h0_exc && h0_wr;
        w2  = p1 && !h1_exc && h1_wr;
        if (w1 && w2 && (h0_dst == h1_dst)) w1 = 1'b0;
        flt = (p0 && h0_exc) || (p1 && h1_exc);

        if (rst) begin
            m_flush = 1'b0; m_cnt = 0; m_fpc = '0; m_ret = '0; m_fl = '0;
        end else begin
            if (m_flush) begin
                if (!freeze) begin
                    m_cnt--;
                    if (m_cnt == 0) m_flush = 1'b0;
                end
            end else if (flt) begin
                m_flush = 1'b1;
                m_cnt   = FC;
                m_fpc   = (p0 && h0_exc) ? h0_pc : h1_pc;
            end
            m_ret = m_ret + 32'(p0) + 32'(p1);
            m_fl  = m_fl + 16'(flt);
        end
        e.r1   = rst ? 1'b0 : w1;
        e.r2   = rst ? 1'b0 : w2;
        e.a1   = (!rst && w1) ? h0_dst  : '0;
        e.d1   = (!rst && w1) ? h0_data : '0;
        e.a2   = (!rst && w2) ? h1_dst  : '0;
        e.d2   = (!rst && w2) ? h1_data : '0;
        e.fr   = rst ? 1'b0 : flt;
        e.fpc  = m_fpc;
        e.busy = m_flush;
        e.sret = m_ret;
        e.sfl  = m_fl;

        #1;
        chk({tag, ".pop0"}, 64'(pop0), 64'(p0));
        chk({tag, ".pop1"}, 64'(pop1), 64'(p1));
        q.push_back(e);

        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, ".queue"}, 64'd0, 64'd1);
        end else begin
            g = q.pop_front();
            chk({tag, ".retire1"}, 64'(retire1), 64'(g.r1));
            chk({tag, ".retire2"}, 64'(retire2), 64'(g.r2));
            chk({tag, ".addr1"},   64'(write_addr1), 64'(g.a1));
            chk({tag, ".data1"},   64'(write_data1), 64'(g.d1));
            chk({tag, ".addr2"},   64'(write_addr2), 64'(g.a2));
            chk({tag, ".data2"},   64'(write_data2), 64'(g.d2));
            chk({tag, ".flush_req"}, 64'(flush_req), 64'(g.fr));
            chk({tag, ".flush_pc"},  64'(flush_pc),  64'(g.fpc));
            chk({tag, ".busy"},      64'(busy_flush), 64'(g.busy));
`ifdef RETIRE_STATS_EN
            chk({tag, ".stat_retired"}, 64'(stat_retired), 64'(g.sret));
            chk({tag, ".stat_flushes"}, 64'(stat_flushes), 64'(g.sfl));
`endif
        end
    endtask

    task automatic both_ready(input logic [5:0] d0, input logic [31:0] v0,
                              input logic [5:0] d1, input logic [31:0] v1);
        set0(1, 1, 0, 1, d0, v0, 32'h100);
        set1(1, 1, 0, 1, d1, v1, 32'h104);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0;
        set0(0, 0, 0, 0, '0, '0, '0);
        set1(0, 0, 0, 0, '0, '0, '0);
        cycle("reset0");
        set0(1, 1, 0, 1, 6'd7, 32'h77, 32'h10);   // ready but reset blocks
        cycle("reset1");
        rst = 1'b0;

        // Dual retire
        both_ready(6'd5, 32'hA, 6'd9, 32'hB);
        cycle("dual");
        set0(0, 0, 0, 0, '0, '0, '0);
        set1(0, 0, 0, 0, '0, '0, '0);
        cycle("idle");

        // Head not done blocks both
        set0(1, 0, 0, 1, 6'd3, 32'h3, 32'h200);
        set1(1, 1, 0, 1, 6'd4, 32'h4, 32'h204);
        cycle("hol");

        // Only head ready
        set0(1, 1, 0, 1, 6'd3, 32'h33, 32'h200);
        set1(1, 0, 0, 1, 6'd4, 32'h44, 32'h204);
        cycle("single");

        // Same-destination collision
        both_ready(6'd12, 32'h1, 6'd12, 32'h2);
        cycle("collide");

        // Fault on head+1: slot 0 commits, flush to 0x400, drain window
        set0(1, 1, 0, 1, 6'd3, 32'h33, 32'h3FC);
        set1(1, 1, 1, 1, 6'd8, 32'h88, 32'h400);
        cycle("exc1");
        both_ready(6'd20, 32'h20, 6'd21, 32'h21);
        for (int i = 0; i < FC; i++) cycle($sformatf("drain%0d", i));
        cycle("resume");

        // Fault on head: slot 1 stays, then reset on second drain cycle
        set0(1, 1, 1, 1, 6'd1, 32'h11, 32'h800);
        set1(1, 1, 0, 1, 6'd2, 32'h22, 32'h804);
        cycle("exc0");
        both_ready(6'd30, 32'h30, 6'd31, 32'h31);
        cycle("fl1");
        rst = 1'b1;
        cycle("fl2rst");
        rst = 1'b0;
        cycle("postrst");

        // Freeze during drain holds the counter
        set0(1, 1, 1, 0, 6'd0, 32'h0, 32'hC00);
        cycle("exc_fz");
        both_ready(6'd40, 32'h40, 6'd41, 32'h41);
        freeze = 1'b1;
        cycle("fz_fl0");
        cycle("fz_fl1");
        freeze = 1'b0;
        for (int i = 0; i < FC; i++) cycle($sformatf("fzdrain%0d", i));

        // Freeze with both ready, then release
        both_ready(6'd50, 32'h50, 6'd51, 32'h51);
        freeze = 1'b1;
        cycle("freeze");
        freeze = 1'b0;
        cycle("release");

        // Randomised traffic
        for (int i = 0; i < 200; i++) begin
            set0($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 6'($urandom_range(0, 3)), $urandom, $urandom);
            set1($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 6'($urandom_range(0, 3)), $urandom, $urandom);
            freeze = ($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
